mem_responder_01: RTL and testbench
===================================

// Module: mem_responder_01
// PURPOSE
//  Memory-side responder for the ALU data bus: the slave end of the
//  rst/clk/wr/addr_bus/data_bus interface the ALU drives as initiator.
//  Accepts one read or write request, inserts programmable wait states,
//  commits or fetches data in a local register array, then pulses ack.
//  The data bus is split into in/out halves; no tristates.
// PARAMETERS
//  bus_width   8   data word width, bits
//  addr_width  8   address bus width, bits
//  mem_depth   16  implemented words; addresses >= mem_depth are out of range
//  wait_states 1   extra cycles between accept and commit (0..15)
// PORTS
//  clk          in   1           rising-edge clock, single domain
//  rst          in   1           synchronous, active-high reset
//  req          in   1           initiator request, level, held until ack
//  wr           in   1           0 = read from memory, 1 = write to memory
//  addr_bus     in   addr_width  word address
//  data_bus_in  in   bus_width   write data from initiator
//  data_bus_out out  bus_width   read data to initiator
//  ack          out  1           one-cycle completion pulse
//  err          out  1           out-of-range flag, valid with ack
//  busy         out  1           transaction in progress (state != IDLE)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, wait counter=0, ack=0, err=0, busy=0,
//   data_bus_out=0, every memory word=0. Dominates all other inputs.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: req=1 at edge k -> latch wr, addr_bus, data_bus_in; counter=wait_states;
//         next = WAIT if wait_states>0, else RESP. req=0 -> stay IDLE.
//   WAIT: counter decrements once per edge; at the edge where counter==1 -> RESP.
//         req/wr/addr/data changes during WAIT are ignored (latched copies used).
//   RESP: ack=1 for exactly this one cycle; next edge -> IDLE unconditionally.
//  Commit happens on the edge entering RESP (edge k+wait_states):
//   write, in range: mem[addr] <= latched data; data_bus_out unchanged.
//   read, in range: data_bus_out <= mem[addr]; holds until the next read commit.
//   out of range (addr >= mem_depth): no memory change; on a read,
//     data_bus_out <= 0; err=1 for the RESP cycle only (same cycle as ack).
//  Latency: ack is high in the cycle after edge k+wait_states, i.e.
//   wait_states+1 cycles after the accepting edge.
//  ack, err and busy are registered or decoded from registered state; none
//   depends combinationally on inputs.
//  Handshake: the initiator drops req in the ack cycle. If req is still 1 in
//   the first IDLE cycle after RESP, it is a new back-to-back transaction.
//   Minimum spacing is one IDLE cycle, so throughput is 1 transaction per
//   wait_states+2 cycles.
//  Read after write to the same address returns the new data: the write
//   commits before any later request is accepted.
//  Address decode uses the full addr_width; no aliasing of high bits.
//  Reset mid-transaction (WAIT or RESP): transaction aborted, no commit;
//   ack is not asserted for it.
// TESTING
//  1 wait_states=1: write addr 3 <- 0xA5, then read addr 3 -> ack 2 cycles
//    after each accept; data_bus_out=0xA5; err=0.
//  2 wait_states=0: back-to-back req held high; write 0x3C@0, read @0 ->
//    ack every 2nd cycle; read returns 0x3C.
//  3 Out of range: read addr 16, write addr 0xFF <- 0x11 -> err=1 with ack,
//    data_bus_out=0x00, mem unchanged (read 15 still returns its old value).
//  4 Latch check: change addr/data_bus_in during WAIT (wait_states=3) ->
//    the originally latched address and data are committed.
//  5 Reset mid-op: assert rst in the WAIT cycle of write 0x77@5 -> no ack;
//    a later read @5 returns 0x00; all outputs are 0 in the cycle after reset.
//  6 Read hold: read 0x5A@2, then write 0x99@2 -> data_bus_out stays 0x5A
//    until the next read.

Source files
------------

// File: rtl/mem_responder_01_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder_01_if
//  Purpose  : ALU data-bus bundle between the ALU (initiator) and the memory
//             responder. The data bus is split into separate in/out halves.
//  Signals  : req          initiator request, level, held until ack
//             wr           0 = read, 1 = write
//             addr_bus     word address
//             data_bus_in  write data from the initiator
//             data_bus_out read data to the initiator
//             ack          one-cycle completion pulse
//             err          out-of-range flag, valid with ack
//             busy         responder has a transaction in flight
//  Revision : 1.0  initial release
// ============================================================================
interface mem_responder_01_if #(
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  req;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr_bus;
  logic [BUS_WIDTH-1:0]  data_bus_in;
  logic [BUS_WIDTH-1:0]  data_bus_out;
  logic                  ack;
  logic                  err;
  logic                  busy;

  modport master (
    output req, wr, addr_bus, data_bus_in,
    input  data_bus_out, ack, err, busy
  );

  modport slave (
    input  req, wr, addr_bus, data_bus_in,
    output data_bus_out, ack, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder_01.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder_01
//  Purpose  : Memory-side responder for the ALU data bus. Accepts one read or
//             write request, inserts WAIT_STATES wait cycles, commits/fetches
//             data in a local register array, then pulses ack for one cycle.
//  Ports    : clk  rising-edge clock
//             rst  synchronous active-high reset
//             bus  mem_responder_01_if.slave (req/wr/addr/data in, data out,
//                  ack/err/busy out)
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder_01 #(
  parameter int BUS_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_responder_01_if.slave  bus
);

  localparam int                c_idx_w = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [3:0]        c_wait  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0]  data_q;
  logic                  err_q;
  logic [BUS_WIDTH-1:0]  dout_q;
  logic [BUS_WIDTH-1:0]  mem_q [MEM_DEPTH];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [BUS_WIDTH-1:0]  w_data;
  logic                  w_in_range;
  logic [c_idx_w-1:0]    w_idx;

  assign w_accept = (state_q == S_IDLE) && bus.req;

  // The commit edge is the one entering RESP. With zero wait states that is
  // the accepting edge itself, so the live bus values are used there; in all
  // other cases the latched copies are used.
  assign w_commit = (state_q == S_IDLE) ? (bus.req && (WAIT_STATES == 0))
                                        : ((state_q == S_WAIT) && (cnt_q == 4'd1));
  assign w_wr     = (state_q == S_IDLE) ? bus.wr          : wr_q;
  assign w_addr   = (state_q == S_IDLE) ? bus.addr_bus    : addr_q;
  assign w_data   = (state_q == S_IDLE) ? bus.data_bus_in : data_q;

  // Full-width compare: high address bits never alias into the array.
  assign w_in_range = ({1'b0, w_addr} < c_depth);
  assign w_idx      = w_addr[c_idx_w-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          cnt_d   = c_wait;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        wr_q   <= bus.wr;
        addr_q <= bus.addr_bus;
        data_q <= bus.data_bus_in;
      end
      // err is only ever set on the commit edge, so it lives for RESP alone.
      err_q <= w_commit && !w_in_range;
      if (w_commit && w_wr && w_in_range) begin
        mem_q[w_idx] <= w_data;
      end
      // Read data holds until the next read commit; writes leave it alone.
      if (w_commit && !w_wr) begin
        dout_q <= w_in_range ? mem_q[w_idx] : '0;
      end
    end
  end

  assign bus.ack          = (state_q == S_RESP);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.err          = err_q;
  assign bus.data_bus_out = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder_01.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder_01
//  Purpose  : Directed self-checking bench for mem_responder_01. Three
//             instances with 0, 1 and 3 wait states share clk and rst.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder_01;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] t_req = '0;
  logic [2:0] t_wr  = '0;
  logic [7:0] t_addr [3];
  logic [7:0] t_din  [3];
  logic [2:0] o_ack, o_err, o_busy;
  logic [7:0] o_dout [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // index 0: 0 wait states, 1: 1 wait state, 2: 3 wait states
  mem_responder_01_if #(.BUS_WIDTH(8), .ADDR_WIDTH(8)) if0 ();
  mem_responder_01_if #(.BUS_WIDTH(8), .ADDR_WIDTH(8)) if1 ();
  mem_responder_01_if #(.BUS_WIDTH(8), .ADDR_WIDTH(8)) if2 ();

  assign if0.req = t_req[0]; assign if0.wr = t_wr[0];
  assign if0.addr_bus = t_addr[0]; assign if0.data_bus_in = t_din[0];
  assign if1.req = t_req[1]; assign if1.wr = t_wr[1];
  assign if1.addr_bus = t_addr[1]; assign if1.data_bus_in = t_din[1];
  assign if2.req = t_req[2]; assign if2.wr = t_wr[2];
  assign if2.addr_bus = t_addr[2]; assign if2.data_bus_in = t_din[2];

  assign o_ack  = {if2.ack,  if1.ack,  if0.ack};
  assign o_err  = {if2.err,  if1.err,  if0.err};
  assign o_busy = {if2.busy, if1.busy, if0.busy};
  assign o_dout[0] = if0.data_bus_out;
  assign o_dout[1] = if1.data_bus_out;
  assign o_dout[2] = if2.data_bus_out;

  mem_responder_01 #(.BUS_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(16), .WAIT_STATES(0))
    u_ws0 (.clk(clk), .rst(rst), .bus(if0));
  mem_responder_01 #(.BUS_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(16), .WAIT_STATES(1))
    u_ws1 (.clk(clk), .rst(rst), .bus(if1));
  mem_responder_01 #(.BUS_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(16), .WAIT_STATES(3))
    u_ws2 (.clk(clk), .rst(rst), .bus(if2));

  // One complete request: drive in an IDLE cycle, count negedges until ack
  // (bounded), capture read data/err in the ack cycle, then drop req.
  // lat = -1 means no ack arrived.
  task automatic txn(input int d, input logic w, input logic [7:0] a,
                     input logic [7:0] dat, output int lat,
                     output logic [7:0] rd, output logic e);
    @(negedge clk);
    t_req[d] = 1'b1; t_wr[d] = w; t_addr[d] = a; t_din[d] = dat;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (o_ack[d]) begin
        lat = i;
        break;
      end
    end
    rd = o_dout[d];
    e  = o_err[d];
    t_req[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({o_ack[d], o_err[d], o_busy[d], o_dout[d]} !== 11'd0) begin
        failures++;
        $display("FAIL reset_outputs dut=%0d got ack=%b err=%b busy=%b dout=%h exp all 0",
                 d, o_ack[d], o_err[d], o_busy[d], o_dout[d]);
      end
    end
  endtask

  task automatic test_basic_rw();
    int lat; logic [7:0] rd; logic e;
    txn(1, 1'b1, 8'd3, 8'hA5, lat, rd, e);
    checks++;
    if (lat !== 2 || e !== 1'b0) begin
      failures++;
      $display("FAIL basic_wr got lat=%0d err=%b exp lat=2 err=0", lat, e);
    end
    txn(1, 1'b0, 8'd3, 8'h00, lat, rd, e);
    checks++;
    if (lat !== 2 || rd !== 8'hA5 || e !== 1'b0) begin
      failures++;
      $display("FAIL basic_rd got lat=%0d data=%h err=%b exp lat=2 data=a5 err=0", lat, rd, e);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    t_req[0] = 1'b1; t_wr[0] = 1'b1; t_addr[0] = 8'd0; t_din[0] = 8'h3C;
    @(negedge clk);
    checks++;
    if (o_ack[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_wr_ack got=%b exp=1", o_ack[0]);
    end
    t_wr[0] = 1'b0; t_din[0] = 8'h00;
    @(negedge clk);
    checks++;
    if (o_ack[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_gap got ack=%b busy=%b exp ack=0 busy=0", o_ack[0], o_busy[0]);
    end
    @(negedge clk);
    checks++;
    if (o_ack[0] !== 1'b1 || o_dout[0] !== 8'h3C) begin
      failures++;
      $display("FAIL b2b_rd got ack=%b data=%h exp ack=1 data=3c", o_ack[0], o_dout[0]);
    end
    t_req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (o_ack[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ack_pulse got=%b exp=0", o_ack[0]);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [7:0] rd; logic e;
    txn(1, 1'b1, 8'd15, 8'hE7, lat, rd, e);
    txn(1, 1'b0, 8'd16, 8'h00, lat, rd, e);
    checks++;
    if (lat !== 2 || e !== 1'b1 || rd !== 8'h00) begin
      failures++;
      $display("FAIL oor_rd16 got lat=%0d err=%b data=%h exp lat=2 err=1 data=00", lat, e, rd);
    end
    @(negedge clk);
    checks++;
    if (o_err[1] !== 1'b0) begin
      failures++;
      $display("FAIL oor_err_pulse got=%b exp=0", o_err[1]);
    end
    txn(1, 1'b1, 8'hFF, 8'h11, lat, rd, e);
    checks++;
    if (lat !== 2 || e !== 1'b1) begin
      failures++;
      $display("FAIL oor_wrff got lat=%0d err=%b exp lat=2 err=1", lat, e);
    end
    txn(1, 1'b0, 8'd15, 8'h00, lat, rd, e);
    checks++;
    if (rd !== 8'hE7 || e !== 1'b0) begin
      failures++;
      $display("FAIL oor_rd15 got data=%h err=%b exp data=e7 err=0", rd, e);
    end
  endtask

  task automatic test_latch();
    int lat; logic [7:0] rd; logic e;
    @(negedge clk);
    t_req[2] = 1'b1; t_wr[2] = 1'b1; t_addr[2] = 8'd7; t_din[2] = 8'hC3;
    @(negedge clk);
    checks++;
    if (o_busy[2] !== 1'b1 || o_ack[2] !== 1'b0) begin
      failures++;
      $display("FAIL latch_wait got busy=%b ack=%b exp busy=1 ack=0", o_busy[2], o_ack[2]);
    end
    t_addr[2] = 8'd8; t_din[2] = 8'h00; t_wr[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (o_ack[2] !== 1'b0) begin
      failures++;
      $display("FAIL latch_early_ack got=%b exp=0", o_ack[2]);
    end
    @(negedge clk);
    checks++;
    if (o_ack[2] !== 1'b1) begin
      failures++;
      $display("FAIL latch_ack got=%b exp=1", o_ack[2]);
    end
    t_req[2] = 1'b0;
    txn(2, 1'b0, 8'd7, 8'h00, lat, rd, e);
    checks++;
    if (lat !== 4 || rd !== 8'hC3) begin
      failures++;
      $display("FAIL latch_rd7 got lat=%0d data=%h exp lat=4 data=c3", lat, rd);
    end
    txn(2, 1'b0, 8'd8, 8'h00, lat, rd, e);
    checks++;
    if (rd !== 8'h00) begin
      failures++;
      $display("FAIL latch_rd8 got data=%h exp data=00", rd);
    end
  endtask

  task automatic test_read_hold();
    int lat; logic [7:0] rd; logic e;
    txn(1, 1'b1, 8'd2, 8'h5A, lat, rd, e);
    txn(1, 1'b0, 8'd2, 8'h00, lat, rd, e);
    checks++;
    if (rd !== 8'h5A) begin
      failures++;
      $display("FAIL hold_rd got=%h exp=5a", rd);
    end
    txn(1, 1'b1, 8'd2, 8'h99, lat, rd, e);
    checks++;
    if (rd !== 8'h5A) begin
      failures++;
      $display("FAIL hold_during_wr got=%h exp=5a", rd);
    end
    @(negedge clk);
    checks++;
    if (o_dout[1] !== 8'h5A) begin
      failures++;
      $display("FAIL hold_after_wr got=%h exp=5a", o_dout[1]);
    end
    txn(1, 1'b0, 8'd2, 8'h00, lat, rd, e);
    checks++;
    if (rd !== 8'h99) begin
      failures++;
      $display("FAIL hold_new_rd got=%h exp=99", rd);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [7:0] rd; logic e;
    @(negedge clk);
    t_req[1] = 1'b1; t_wr[1] = 1'b1; t_addr[1] = 8'd5; t_din[1] = 8'h77;
    @(negedge clk);
    checks++;
    if (o_busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_wait got busy=%b exp=1", o_busy[1]);
    end
    rst = 1'b1; t_req[1] = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_ack[1], o_err[1], o_busy[1], o_dout[1]} !== 11'd0) begin
      failures++;
      $display("FAIL midrst_outputs got ack=%b err=%b busy=%b dout=%h exp all 0",
               o_ack[1], o_err[1], o_busy[1], o_dout[1]);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_ack[1] !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_ack got=%b exp=0", o_ack[1]);
    end
    txn(1, 1'b0, 8'd5, 8'h00, lat, rd, e);
    checks++;
    if (lat !== 2 || rd !== 8'h00) begin
      failures++;
      $display("FAIL midrst_rd5 got lat=%0d data=%h exp lat=2 data=00", lat, rd);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      t_addr[d] = '0;
      t_din[d]  = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic_rw();
    test_back_to_back();
    test_out_of_range();
    test_latch();
    test_read_hold();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
